sha1_digest_capture: RTL and testbench
======================================

# sha1_digest_capture

Downstream consumer of the SHA-1 round pipeline's `A` output stream. It keeps a 5-deep history of `A` and, on each end-of-block strobe, reconstructs the 160-bit digest and adds the initial hash values. Digests are buffered in a 2-entry FIFO with a valid/ready handshake toward the host/result path. An optional compare stage filters digests against a masked target.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: output FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  input  1: single clock; all logic on rising edge.
- `reset`  input  1: synchronous, active-high.
- `A`  input  32: round pipeline output; one round result per cycle.
- `last_in`  input  1: high on the cycle `A` holds round-80 output.
- `target`  input  32: compare value for digest word a. Present only with the macro.
- `mask`  input  32: compare mask for digest word a. Present only with the macro.
- `out_digest`  output  160: {a,b,c,d,e}, with a in [159:128].
- `out_match`  output  1: compare result for the head entry.
- `out_valid`  output  1: FIFO head valid.
- `out_ready`  input  1: consumer accepts the head when high together with `out_valid`.
- `spacing_err`  output  1: sticky; set when strobes are spaced too closely.
- `overflow`  output  1: sticky; set when a digest is dropped.
- `digest_count`  output  32: number of digests enqueued, wrapping.
- `drop_count`  output  16: number of digests dropped, saturating at 0xFFFF.

## Operation
- History: `H0..H4` is a shift register of `A`, updated every cycle (`H0` is the newest). On the cycle `last_in` is high, `A`=A80, `H0`=A79, `H1`=A78, `H2`=A77, `H3`=A76.
- Digest stage (registered on the edge ending the `last_in` cycle):
  - a = A80 + 67452301
  - b = A79 + efcdab89
  - c = rol30(A78) + 98badcfe
  - d = rol30(A77) + 10325476
  - e = rol30(A76) + c3d2e1f0
  - All additions are mod 2^32. rol30 is rotate left by 30.
- Stage valid bit `dv` follows `last_in` with one cycle of delay.
- Enqueue: when `dv` is high and the entry passes the filter, the entry is written to the FIFO.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped: `overflow` is set and `drop_count` increments.
  - If the FIFO is full and a pop happens the same cycle, the push is accepted with no drop.
- Spacing check: a 3-bit counter counts cycles since the last `last_in`. If `last_in` arrives fewer than 5 cycles after the previous one, `spacing_err` is set. The digest is still computed from the history as it stands.
- The first `last_in` after reset is never flagged by the spacing check.
- Pop: `out_valid && out_ready` removes the head. Popping while empty has no effect.
- `digest_count` increments on every accepted push.

## Timing
- Latency:
  - `last_in` at cycle t: digest registered at t+1.
  - FIFO write at the t+1 edge.
  - `out_valid` high at t+2 if the FIFO was empty.
- Throughput: one digest per 5 cycles, sustained when `out_ready` is held high.
- `out_digest` and `out_match` are stable while `out_valid` is high and `out_ready` is low.
- Reset values:
  - Outputs: `out_valid`=0, `out_match`=0, `out_digest`=0, `spacing_err`=0, `overflow`=0, `digest_count`=0, `drop_count`=0.
  - Internal: FIFO empty, `dv`=0, history=0, spacing counter marked "no previous strobe".
- Reset asserted mid-operation discards any in-flight `dv` and all FIFO contents on the same edge.
- A `last_in` in the same cycle as `reset` is ignored.

## Configuration
- `SHA1_CAPTURE_COMPARE_EN` defined:
  - `target`/`mask` ports exist.
  - Match = ((a ^ `target`) & `mask`) == 0, registered alongside the digest.
  - Only matching digests are enqueued. `out_match`=1 for every entry.
  - Non-matching digests do not count as drops.
- `SHA1_CAPTURE_COMPARE_EN` undefined:
  - No `target`/`mask` ports.
  - Every digest is enqueued.
  - `out_match` is tied 0.

## Test plan
- SHA-1("abc"): drive A76..A80 = 63F7DAB7, A0793B7D9… correction, A77 = A079B7D9, A78 = 860D21CC, A79 = 5738D5E1, A80 = 42541B35, with `last_in` on A80 and `out_ready`=1.
  - Required: `out_valid` 2 cycles later, `out_digest` = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, `digest_count`=1.
- Back-pressure: hold `out_ready`=0 and issue 3 strobes 5 cycles apart.
  - Required: first 2 digests held in order; the third is dropped; `overflow`=1, `drop_count`=1, `digest_count`=2.
- Push and pop in the same cycle while full: no drop, `overflow` stays 0.
- Spacing: two `last_in` pulses 3 cycles apart.
  - Required: `spacing_err`=1 after the second pulse, both digests enqueued, flag stays sticky until `reset`.
- Compare (macro on):
  - With `target`=42541B35, `mask`=FFFF0000: for a = 4254xxxx, the entry is enqueued with `out_match`=1.
  - With a = 43000000: nothing is enqueued, `drop_count` stays 0.
- Reset mid-run: assert `reset` one cycle after `last_in`.
  - Required: `out_valid` stays 0 and all counters and flags read 0 on the following cycle.

Source files
------------

// File: rtl/sha1_digest_capture.sv
// -----------------------------------------------------------------------------
// sha1_digest_capture
//
// Consumes the SHA-1 round pipeline's A output stream. On each end-of-block
// strobe it rebuilds the 160-bit digest from the recent history of A, adds the
// SHA-1 initial hash values, and pushes the result into a small output FIFO
// with a valid/ready handshake.
//
// Optional feature macro: SHA1_CAPTURE_COMPARE_EN
//   When defined, the target/mask ports exist and only digests whose word a
//   satisfies ((a ^ target) & mask) == 0 are enqueued (out_match=1 for them).
//   When undefined, every digest is enqueued and out_match is tied 0.
//
// Parameters:
//   FIFO_DEPTH   output FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   A            round pipeline output, one round result per cycle
//   last_in      high on the cycle A holds the round-80 result
//   target/mask  compare value and mask for digest word a (macro only)
//   out_digest   FIFO head {a,b,c,d,e}, a in [159:128]; 0 when empty
//   out_match    compare result for the FIFO head
//   out_valid    FIFO head valid
//   out_ready    consumer accepts the head when high with out_valid
//   spacing_err  sticky: strobes arrived fewer than 5 cycles apart
//   overflow     sticky: a digest was dropped on a full FIFO
//   digest_count digests enqueued, wrapping
//   drop_count   digests dropped, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module sha1_digest_capture #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  A,
  input  logic         last_in,
`ifdef SHA1_CAPTURE_COMPARE_EN
  input  logic [31:0]  target,
  input  logic [31:0]  mask,
`endif
  output logic [159:0] out_digest,
  output logic         out_match,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         spacing_err,
  output logic         overflow,
  output logic [31:0]  digest_count,
  output logic [15:0]  drop_count
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // History. The live input A is the newest of the five values (A80), so only
  // four registered slots are needed: r_hist[0]=A79 ... r_hist[3]=A76 on the
  // strobe cycle.
  // ---------------------------------------------------------------------------
  logic [31:0] r_hist [0:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
    end else begin
      r_hist[0] <= A;
      for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // Words c, d and e come from A78..A76, which the round function has already
  // rotated by 30 when it shifted them into C/D/E.
  logic [31:0] w_rot [1:3];
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_rot
      assign w_rot[gi] = {r_hist[gi][1:0], r_hist[gi][31:2]};
    end
  endgenerate

  logic [31:0] w_a, w_b, w_c, w_d, w_e;
  assign w_a = A          + 32'h6745_2301;
  assign w_b = r_hist[0]  + 32'hEFCD_AB89;
  assign w_c = w_rot[1]   + 32'h98BA_DCFE;
  assign w_d = w_rot[2]   + 32'h1032_5476;
  assign w_e = w_rot[3]   + 32'hC3D2_E1F0;

  // ---------------------------------------------------------------------------
  // Digest stage
  // ---------------------------------------------------------------------------
  logic [159:0] r_digest;
  logic         r_dv;
  logic         w_pass;

`ifdef SHA1_CAPTURE_COMPARE_EN
  logic r_match;
  logic w_match;
  assign w_match = (((w_a ^ target) & mask) == 32'h0);
  assign w_pass  = r_match;
`else
  assign w_pass  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dv     <= 1'b0;
      r_digest <= '0;
`ifdef SHA1_CAPTURE_COMPARE_EN
      r_match  <= 1'b0;
`endif
    end else begin
      r_dv <= last_in;
      if (last_in) begin
        r_digest <= {w_a, w_b, w_c, w_d, w_e};
`ifdef SHA1_CAPTURE_COMPARE_EN
        r_match  <= w_match;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. Pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [159:0] r_mem [0:FIFO_DEPTH-1];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]  w_count;
  logic         w_empty, w_full, w_pop, w_push_req, w_push, w_drop;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == DEPTH_L);
  assign w_pop      = !w_empty && out_ready;
  assign w_push_req = r_dv && w_pass;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_digest;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign out_valid  = !w_empty;
  // Forced to zero when empty so stale storage never shows on the port.
  assign out_digest = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

`ifdef SHA1_CAPTURE_COMPARE_EN
  // Only matching digests are ever stored, so every valid head matched.
  assign out_match = out_valid;
`else
  assign out_match = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Strobe spacing. r_gap = cycles since the previous strobe, saturating at 7;
  // 0 means no strobe seen since reset, so the first strobe is never flagged.
  // ---------------------------------------------------------------------------
  logic [2:0] r_gap;
  logic       r_spacing_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap         <= 3'd0;
      r_spacing_err <= 1'b0;
    end else if (last_in) begin
      if ((r_gap != 3'd0) && (r_gap < 3'd5)) r_spacing_err <= 1'b1;
      r_gap <= 3'd1;
    end else if ((r_gap != 3'd0) && (r_gap != 3'd7)) begin
      r_gap <= r_gap + 3'd1;
    end
  end

  assign spacing_err = r_spacing_err;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic        r_overflow;
  logic [31:0] r_digest_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow     <= 1'b0;
      r_digest_count <= '0;
      r_drop_count   <= '0;
    end else begin
      if (w_push) r_digest_count <= r_digest_count + 32'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign overflow     = r_overflow;
  assign digest_count = r_digest_count;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_sha1_digest_capture.sv
// -----------------------------------------------------------------------------
// tb_sha1_digest_capture
//
// Directed bench for sha1_digest_capture: SHA-1("abc") reconstruction,
// back-pressure and overflow, push/pop while full, strobe spacing, reset
// behaviour and (with SHA1_CAPTURE_COMPARE_EN) the compare filter.
// -----------------------------------------------------------------------------
module tb_sha1_digest_capture;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  a_in;
  logic         last_in;
  logic [31:0]  target;
  logic [31:0]  mask;
  logic [159:0] out_digest;
  logic         out_match;
  logic         out_valid;
  logic         out_ready;
  logic         spacing_err;
  logic         overflow;
  logic [31:0]  digest_count;
  logic [15:0]  drop_count;

  always #5 clk = ~clk;

  sha1_digest_capture #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .A            (a_in),
    .last_in      (last_in),
`ifdef SHA1_CAPTURE_COMPARE_EN
    .target       (target),
    .mask         (mask),
`endif
    .out_digest   (out_digest),
    .out_match    (out_match),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .spacing_err  (spacing_err),
    .overflow     (overflow),
    .digest_count (digest_count),
    .drop_count   (drop_count)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Shadow of the last four A values driven (index 0 newest) and the most
  // recent expected digest.
  logic [31:0]  sh [4];
  logic [159:0] last_exp;

`ifdef SHA1_CAPTURE_COMPARE_EN
  localparam logic EXP_MATCH = 1'b1;
`else
  localparam logic EXP_MATCH = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [31:0] rol30(input logic [31:0] x);
    return (x << 30) | (x >> 2);
  endfunction

  function automatic logic [159:0] model(input logic [31:0] a76, input logic [31:0] a77,
                                         input logic [31:0] a78, input logic [31:0] a79,
                                         input logic [31:0] a80);
    logic [31:0] wa, wb, wc, wd, we;
    wa = a80 + 32'h67452301;
    wb = a79 + 32'hEFCDAB89;
    wc = rol30(a78) + 32'h98BADCFE;
    wd = rol30(a77) + 32'h10325476;
    we = rol30(a76) + 32'hC3D2E1F0;
    return {wa, wb, wc, wd, we};
  endfunction

  // One clock of stimulus; returns 1 ns after the rising edge.
  task automatic drive(input logic [31:0] v, input logic last);
    a_in    = v;
    last_in = last;
    if (last && !reset) last_exp = model(sh[3], sh[2], sh[1], sh[0], v);
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 4; i++) sh[i] = '0;
    end else begin
      for (int i = 3; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = v;
    end
    last_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h5A5A0000 + 32'(i), 1'b0);
  endtask

  // Five consecutive rounds A76..A80 with the strobe on A80.
  task automatic send_block(input logic [31:0] v76, input logic [31:0] v77,
                            input logic [31:0] v78, input logic [31:0] v79,
                            input logic [31:0] v80);
    drive(v76, 1'b0);
    drive(v77, 1'b0);
    drive(v78, 1'b0);
    drive(v79, 1'b0);
    drive(v80, 1'b1);
  endtask

  task automatic send_seed(input logic [31:0] s);
    send_block(s, s ^ 32'h01010101, s ^ 32'h20202020, s + 32'h13579BDF, ~s);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  logic [159:0] d1, d2, d3;

  initial begin
    reset = 1'b1; a_in = '0; last_in = 1'b0; out_ready = 1'b0;
    target = '0; mask = '0;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    last_exp = '0;

    // ---------------- reset state ----------------
    do_reset();
    check_eq("rst out_valid",    160'(out_valid),    160'd0);
    check_eq("rst out_match",    160'(out_match),    160'd0);
    check_eq("rst out_digest",   out_digest,         160'd0);
    check_eq("rst spacing_err",  160'(spacing_err),  160'd0);
    check_eq("rst overflow",     160'(overflow),     160'd0);
    check_eq("rst digest_count", 160'(digest_count), 160'd0);
    check_eq("rst drop_count",   160'(drop_count),   160'd0);

    // ---------------- SHA-1("abc") ----------------
    out_ready = 1'b1;
    send_block(32'h63F7DAB7, 32'hA079B7D9, 32'h860D21CC, 32'h5738D5E1, 32'h42541B35);
    check_eq("abc valid t+1", 160'(out_valid), 160'd0);
    idle(1);
    check_eq("abc valid t+2", 160'(out_valid), 160'd1);
    check_eq("abc digest", out_digest,
             160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);
    check_eq("abc match", 160'(out_match), 160'(EXP_MATCH));
    check_eq("abc digest_count", 160'(digest_count), 160'd1);
    check_eq("abc spacing_err", 160'(spacing_err), 160'd0);
    idle(1);
    check_eq("abc popped", 160'(out_valid), 160'd0);
    out_ready = 1'b0;

    // ---------------- back-pressure / overflow ----------------
    do_reset();
    send_seed(32'h11112222); d1 = last_exp;
    send_seed(32'h33334444); d2 = last_exp;
    send_seed(32'h55556666);
    idle(1);
    check_eq("bp overflow",     160'(overflow),     160'd1);
    check_eq("bp drop_count",   160'(drop_count),   160'd1);
    check_eq("bp digest_count", 160'(digest_count), 160'd2);
    check_eq("bp spacing_err",  160'(spacing_err),  160'd0);
    check_eq("bp head1",        out_digest,         d1);
    idle(2);
    check_eq("bp head1 held",   out_digest,         d1);
    pop_one();
    check_eq("bp head2",        out_digest,         d2);
    pop_one();
    check_eq("bp empty",        160'(out_valid),    160'd0);

    // ---------------- push and pop while full ----------------
    do_reset();
    send_seed(32'h0BADF00D); d1 = last_exp;
    send_seed(32'hCAFE1234); d2 = last_exp;
    send_seed(32'h87654321); d3 = last_exp;
    pop_one();
    check_eq("pp overflow",     160'(overflow),     160'd0);
    check_eq("pp drop_count",   160'(drop_count),   160'd0);
    check_eq("pp digest_count", 160'(digest_count), 160'd3);
    check_eq("pp head2",        out_digest,         d2);
    pop_one();
    check_eq("pp head3",        out_digest,         d3);
    pop_one();
    check_eq("pp empty",        160'(out_valid),    160'd0);

    // ---------------- spacing ----------------
    do_reset();
    send_seed(32'hFEEDBEEF); d1 = last_exp;
    drive(32'h01234567, 1'b0);
    drive(32'h89ABCDEF, 1'b0);
    drive(32'h0F1E2D3C, 1'b1); d2 = last_exp;
    check_eq("sp flag",         160'(spacing_err),  160'd1);
    idle(1);
    check_eq("sp digest_count", 160'(digest_count), 160'd2);
    check_eq("sp drop_count",   160'(drop_count),   160'd0);
    check_eq("sp head1",        out_digest,         d1);
    pop_one();
    check_eq("sp head2",        out_digest,         d2);
    pop_one();
    idle(10);
    check_eq("sp sticky",       160'(spacing_err),  160'd1);
    do_reset();
    check_eq("sp cleared",      160'(spacing_err),  160'd0);

    // ---------------- strobe during reset is ignored ----------------
    reset = 1'b1;
    drive(32'h77777777, 1'b1);
    reset = 1'b0;
    drive(32'h42541B35, 1'b1); d1 = last_exp;
    idle(1);
    check_eq("rs no flag",      160'(spacing_err),  160'd0);
    check_eq("rs digest_count", 160'(digest_count), 160'd1);
    check_eq("rs head",         out_digest,         d1);
    pop_one();

    // ---------------- reset mid-run ----------------
    do_reset();
    send_seed(32'hA5A5A5A5);
    send_seed(32'h5A5A5A5A);
    send_seed(32'hC3C3C3C3);
    idle(1);
    check_eq("mr pre overflow", 160'(overflow),     160'd1);
    send_seed(32'h3C3C3C3C);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_eq("mr out_valid",    160'(out_valid),    160'd0);
    check_eq("mr out_digest",   out_digest,         160'd0);
    check_eq("mr overflow",     160'(overflow),     160'd0);
    check_eq("mr digest_count", 160'(digest_count), 160'd0);
    check_eq("mr drop_count",   160'(drop_count),   160'd0);
    idle(3);
    check_eq("mr still empty",  160'(out_valid),    160'd0);

`ifdef SHA1_CAPTURE_COMPARE_EN
    // ---------------- compare filter ----------------
    do_reset();
    target = 32'h42541B35;
    mask   = 32'hFFFF0000;
    send_block(32'h1, 32'h2, 32'h3, 32'h4, 32'hDB0EEF33);
    idle(1);
    check_eq("cmp hit valid",   160'(out_valid),    160'd1);
    check_eq("cmp hit match",   160'(out_match),    160'd1);
    check_eq("cmp hit word a",  160'(out_digest[159:128]), 160'h42541234);
    pop_one();
    send_block(32'h1, 32'h2, 32'h3, 32'h4, 32'hDBBADCFF);
    idle(2);
    check_eq("cmp miss valid",  160'(out_valid),    160'd0);
    check_eq("cmp miss drops",  160'(drop_count),   160'd0);
    check_eq("cmp miss count",  160'(digest_count), 160'd1);
    target = '0;
    mask   = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
